// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed FIR controller: one shared signed MAC walks N_TAPS taps per
// accepted sample, with a run-time-writable coefficient bank and valid/ready input.
module fir_tap_sequencer #(
  parameter int N_TAPS  = 4,
  parameter int BW_in   = 2,
  parameter int BW_coef = 2,
  parameter int BW_acc  = 6,
  parameter int BW_out  = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [BW_in-1:0]     x_in,
  input  logic                        x_valid,
  output logic                        x_ready,
  input  logic                        cfg_we,
  input  logic [$clog2(N_TAPS)-1:0]   cfg_addr,
  input  logic signed [BW_coef-1:0]   cfg_data,
  output logic signed [BW_out-1:0]    y_out,
  output logic                        y_valid,
  output logic                        busy
);

  localparam int AW = $clog2(N_TAPS);
  localparam int PW = BW_in + BW_coef;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                    state;
  logic [AW-1:0]             k;
  logic signed [BW_acc-1:0]  acc;
  logic signed [BW_in-1:0]   xd   [N_TAPS];
  logic signed [BW_coef-1:0] coef [N_TAPS];
  logic signed [PW-1:0]      prod;
  logic signed [BW_acc-1:0]  prod_ext;

  // Operands widened to the full product width before multiplying so the
  // signed product never overflows; then sign-extended into the accumulator.
  always_comb begin
    prod     = PW'(coef[k]) * PW'(xd[k]);
    prod_ext = BW_acc'(prod);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      x_ready <= 1'b1;
      busy    <= 1'b0;
      y_valid <= 1'b0;
      y_out   <= '0;
      acc     <= '0;
      k       <= '0;
      for (int unsigned i = 0; i < N_TAPS; i++) begin
        xd[i]   <= '0;
        coef[i] <= '0;
      end
      // Power-up response y[n] = x[n-1] - x[n]
      coef[0] <= '1;
      coef[1] <= BW_coef'(1);
    end else begin
      y_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_we && (int'(cfg_addr) < N_TAPS))
            coef[cfg_addr] <= cfg_data;
          if (x_valid) begin
            xd[0] <= x_in;
            for (int unsigned i = 1; i < N_TAPS; i++)
              xd[i] <= xd[i-1];
            acc     <= '0;
            k       <= '0;
            state   <= MAC;
            x_ready <= 1'b0;
            busy    <= 1'b1;
          end
        end
        MAC: begin
          acc <= acc + prod_ext;
          k   <= k + 1'b1;
          if (k == AW'(N_TAPS - 1))
            state <= DONE;
        end
        DONE: begin
          y_out   <= acc[BW_acc-1 -: BW_out];
          y_valid <= 1'b1;
          state   <= IDLE;
          x_ready <= 1'b1;
          busy    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed scenarios plus random samples/coefficients for fir_tap_sequencer,
// checked against a convolution-level reference model.
module tb_fir_tap_sequencer;

  localparam int N       = 4;
  localparam int BW_in   = 2;
  localparam int BW_coef = 2;
  localparam int BW_acc  = 6;
  localparam int BW_out  = 3;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic signed [BW_in-1:0]   x_in = '0;
  logic                      x_valid = 1'b0;
  logic                      x_ready;
  logic                      cfg_we = 1'b0;
  logic [$clog2(N)-1:0]      cfg_addr = '0;
  logic signed [BW_coef-1:0] cfg_data = '0;
  logic [BW_out-1:0]         y_out;
  logic                      y_valid;
  logic                      busy;

  fir_tap_sequencer #(
    .N_TAPS(N), .BW_in(BW_in), .BW_coef(BW_coef), .BW_acc(BW_acc), .BW_out(BW_out)
  ) dut (
    .clk(clk), .reset(reset), .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .y_out(y_out), .y_valid(y_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_assert = 0;
  int n_fail   = 0;
  int cm [N];
  int xm [N];
  int last_y   = 0;
  int last_acc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      cm[i] = 0;
      xm[i] = 0;
    end
    cm[0]  = -1;
    cm[1]  = 1;
    last_y = 0;
  endtask

  // Full dot product, wrapped to the accumulator range, then floor-divided.
  function automatic int model_y();
    int sum = 0;
    int w;
    for (int i = 0; i < N; i++) sum += cm[i] * xm[i];
    w = ((sum % 64) + 64) % 64;
    if (w >= 32) w -= 64;
    return (w >>> 3) & 7;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; x_valid = 1'b0; cfg_we = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("rst_x_ready", x_ready, 1);
    check("rst_busy",    busy,    0);
    check("rst_y_valid", y_valid, 0);
    check("rst_y_out",   y_out,   0);
  endtask

  task automatic write_cfg(input int a, input int d);
    cfg_we = 1'b1; cfg_addr = a[1:0]; cfg_data = d[1:0];
    @(negedge clk);
    cfg_we = 1'b0;
    if (a < N) cm[a] = d;
  endtask

  task automatic run_sample(input int v, input bit hold, input bit mid_cfg,
                            input bit same_cfg, input int ca, input int cd,
                            input bit check_gap);
    int budget = 0;
    int acc_cyc;
    int exp_y;
    x_in = v[1:0]; x_valid = 1'b1;
    if (same_cfg) begin
      cfg_we = 1'b1; cfg_addr = ca[1:0]; cfg_data = cd[1:0];
    end
    while (x_ready !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (x_ready !== 1'b1) begin
      check("accept_timeout", x_ready, 1);
      x_valid = 1'b0; cfg_we = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (same_cfg) begin
      cm[ca] = cd;
      cfg_we = 1'b0;
    end
    for (int i = N - 1; i > 0; i--) xm[i] = xm[i-1];
    xm[0] = v;
    exp_y = model_y();
    if (check_gap) check("accept_gap", acc_cyc - last_acc, N + 2);
    last_acc = acc_cyc;
    x_in = BW_in'($urandom);
    if (!hold) x_valid = 1'b0;
    for (int i = 0; i <= N; i++) begin
      @(negedge clk);
      check("x_ready_low", x_ready, 0);
      check("busy_high",   busy,    1);
      check("y_valid_low", y_valid, 0);
      check("y_out_hold",  y_out,   last_y);
      if (mid_cfg && i == 1) begin
        cfg_we = 1'b1; cfg_addr = '0; cfg_data = 2'sd1;
      end
      if (mid_cfg && i == 2) cfg_we = 1'b0;
    end
    @(negedge clk);
    check("y_valid_pulse", y_valid, 1);
    check("y_out",         y_out,   exp_y);
    check("busy_done",     busy,    0);
    check("x_ready_back",  x_ready, 1);
    last_y = exp_y;
  endtask

  initial begin
    bit held;
    bit h;
    bit sc;
    model_reset();

    // Default differentiator: 1, -1, 0
    do_reset();
    run_sample(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("y_valid_one_cycle", y_valid, 0);
    run_sample(-1, 0, 0, 0, 0, 0, 0);
    run_sample(0, 0, 0, 0, 0, 0, 0);

    // All coefficients -2, back-to-back -2 samples with x_valid held
    do_reset();
    for (int i = 0; i < N; i++) write_cfg(i, -2);
    run_sample(-2, 1, 0, 0, 0, 0, 0);
    run_sample(-2, 1, 0, 0, 0, 0, 1);
    run_sample(-2, 1, 0, 0, 0, 0, 1);
    run_sample(-2, 1, 0, 0, 0, 0, 1);

    // Coefficient write during MAC is ignored; held sample taken on first IDLE edge
    run_sample(-2, 1, 1, 0, 0, 0, 1);
    run_sample(1, 0, 0, 0, 0, 0, 1);

    // Reset mid-MAC aborts and restores coefficients and delay line
    do_reset();
    write_cfg(0, 1);
    write_cfg(1, -2);
    run_sample(0, 0, 0, 0, 0, 0, 0);
    x_in = 2'sd1; x_valid = 1'b1;
    @(posedge clk);
    #1;
    x_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("abort_y_out",   y_out,   0);
    check("abort_x_ready", x_ready, 1);
    check("abort_busy",    busy,    0);
    for (int i = 0; i < N + 2; i++) begin
      check("abort_no_y_valid", y_valid, 0);
      @(negedge clk);
    end
    run_sample(1, 0, 0, 0, 0, 0, 0);

    // Same-edge coefficient write and accept
    do_reset();
    run_sample(1, 0, 0, 0, 0, 0, 0);
    run_sample(0, 0, 0, 0, 0, 0, 0);
    run_sample(1, 0, 0, 1, 2, 1, 0);

    // Random samples, coefficients and idle gaps
    held = 1'b0;
    for (int it = 0; it < 30; it++) begin
      if (!held) begin
        if ($urandom_range(0, 1) == 1)
          write_cfg(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 3)) - 2);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      h  = (it != 29) && ($urandom_range(0, 1) == 1);
      sc = ($urandom_range(0, 3) == 0);
      run_sample(int'($urandom_range(0, 3)) - 2, h, 0, sc,
                 int'($urandom_range(0, N - 1)), int'($urandom_range(0, 3)) - 2, held);
      held = h;
    end
    @(negedge clk);
    check("final_y_valid_low", y_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
